// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : icache_pkg
// Purpose : Shared types, default geometry and tree pseudo-LRU helpers for icache_nway.
// Revision: 1.0
// ============================================================================
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2,
        FLUSH = 2'd3
    } state_e;

    localparam int WAYS_DEF      = 4;
    localparam int SETS_DEF      = 8;
    localparam int LINE_BITS_DEF = 256;
    localparam int OFFSET_BITS   = $clog2(LINE_BITS_DEF / 8);
    localparam int IDX_BITS      = $clog2(SETS_DEF);
    localparam int TAG_BITS      = 32 - OFFSET_BITS - IDX_BITS;

    // Helpers work on a fixed 16-way-wide tree; callers zero-extend and truncate.
    localparam int MAX_LEVELS = 4;
    localparam int PLRU_MAX_W = (1 << MAX_LEVELS) - 1;
    localparam int WAY_MAX_W  = MAX_LEVELS;

    // Heap-ordered tree: node n has children 2n+1 (lower ways) and 2n+2 (upper ways).
    function automatic logic [PLRU_MAX_W-1:0] plru_touch(
        input logic [PLRU_MAX_W-1:0] bits,
        input logic [WAY_MAX_W-1:0]  way,
        input int                    levels
    );
        logic [PLRU_MAX_W-1:0] r;
        logic [WAY_MAX_W-1:0]  path;
        logic [WAY_MAX_W-1:0]  node;
        logic                  dir;
        r    = bits;
        path = way << (WAY_MAX_W - levels);
        node = '0;
        for (int l = 0; l < MAX_LEVELS; l++) begin
            if (l < levels) begin
                dir     = path[WAY_MAX_W-1];
                r[node] = ~dir;
                node    = (node << 1) + WAY_MAX_W'(1) + {{(WAY_MAX_W-1){1'b0}}, dir};
                path    = path << 1;
            end
        end
        return r;
    endfunction

    function automatic logic [WAY_MAX_W-1:0] plru_victim(
        input logic [PLRU_MAX_W-1:0] bits,
        input int                    levels
    );
        logic [WAY_MAX_W-1:0] v;
        logic [WAY_MAX_W-1:0] node;
        logic                 dir;
        v    = '0;
        node = '0;
        for (int l = 0; l < MAX_LEVELS; l++) begin
            if (l < levels) begin
                dir  = bits[node];
                v    = {v[WAY_MAX_W-2:0], dir};
                node = (node << 1) + WAY_MAX_W'(1) + {{(WAY_MAX_W-1){1'b0}}, dir};
            end
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_plru.sv
`default_nettype none
// ============================================================================
// Module  : icache_plru
// Purpose : Per-set tree pseudo-LRU state with touch, whole-cache clear and victim lookup.
// Revision: 1.0
// ============================================================================
module icache_plru
    import icache_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    touch_en,
    input  logic [$clog2(SETS)-1:0] touch_set,
    input  logic [$clog2(WAYS)-1:0] touch_way,
    input  logic [$clog2(SETS)-1:0] query_set,
    output logic [$clog2(WAYS)-1:0] victim_way
);

    localparam int NODES  = WAYS - 1;
    localparam int LEVELS = $clog2(WAYS);
    localparam int WAY_W  = $clog2(WAYS);

    logic [NODES-1:0] plru_q [SETS];
    logic [NODES-1:0] plru_d [SETS];

    always_comb begin
        plru_d = plru_q;
        if (clear) begin
            plru_d = '{default: '0};
        end else if (touch_en) begin
            plru_d[touch_set] = NODES'(plru_touch(PLRU_MAX_W'(plru_q[touch_set]),
                                                  WAY_MAX_W'(touch_way), LEVELS));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            plru_q <= '{default: '0};
        end else begin
            plru_q <= plru_d;
        end
    end

    assign victim_way = WAY_W'(plru_victim(PLRU_MAX_W'(plru_q[query_set]), LEVELS));

endmodule
`default_nettype wire

// File: rtl/icache_nway.sv
`default_nettype none
// ============================================================================
// Module  : icache_nway
// Purpose : N-way set-associative read-only instruction cache with tree PLRU and flush.
//           Define ICACHE_PERF_CNT_EN to add hit_count/miss_count output ports.
// Revision: 1.0
// ============================================================================
module icache_nway
    import icache_pkg::*;
#(
    parameter int WAYS      = WAYS_DEF,
    parameter int SETS      = SETS_DEF,
    parameter int LINE_BITS = LINE_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic [31:0]          mem_address,
    output logic [LINE_BITS-1:0] mem_rdata,
    output logic                 mem_resp,
    input  logic                 flush,
    output logic                 flush_ack,
    output logic                 pmem_read,
    output logic [31:0]          pmem_address,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
`endif
);

    localparam int OFF_W  = $clog2(LINE_BITS / 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int LINE_W = 32 - OFF_W;

    state_e              state_q, state_d;
    logic                flush_pend_q, flush_pend_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAYS-1:0]     valid_d [SETS];
    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
    logic [LINE_BITS-1:0] data_q [SETS][WAYS];

    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic                unused_offset;

    logic [WAYS-1:0]            hit_vec;
    logic                       hit;
    logic [WAYS:0][WAY_W-1:0]   hit_or;
    logic [WAYS:0][WAY_W-1:0]   inv_chain;
    logic [WAY_W-1:0]           hit_way;
    logic [WAY_W-1:0]           inv_way;
    logic                       inv_found;
    logic [WAY_W-1:0]           plru_way;

    logic                fill_we;
    logic                touch_en;
    logic [IDX_W-1:0]    touch_set;
    logic [WAY_W-1:0]    touch_way;
    logic [IDX_W-1:0]    rd_set;
    logic [WAY_W-1:0]    rd_way;

    assign req_idx       = mem_address[OFF_W +: IDX_W];
    assign req_tag       = mem_address[31 -: TAG_W];
    assign fill_idx      = line_q[IDX_W-1:0];
    assign fill_tag      = line_q[LINE_W-1 -: TAG_W];
    assign unused_offset = ^mem_address[OFF_W-1:0];

    // Lookup: hit_or accumulates the matching way, inv_chain resolves to the lowest invalid way.
    assign hit_or[0]       = '0;
    assign inv_chain[WAYS] = '0;
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign hit_vec[w]   = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
        assign hit_or[w+1]  = hit_or[w] | (hit_vec[w] ? WAY_W'(w) : '0);
        assign inv_chain[w] = valid_q[req_idx][w] ? inv_chain[w+1] : WAY_W'(w);
    end

    assign hit       = |hit_vec;
    assign hit_way   = hit_or[WAYS];
    assign inv_way   = inv_chain[0];
    assign inv_found = ~&valid_q[req_idx];

    icache_plru #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_plru (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_q == FLUSH),
        .touch_en   (touch_en),
        .touch_set  (touch_set),
        .touch_way  (touch_way),
        .query_set  (req_idx),
        .victim_way (plru_way)
    );

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        victim_d     = victim_q;
        line_d       = line_q;
        mem_resp     = 1'b0;
        flush_ack    = 1'b0;
        pmem_read    = 1'b0;
        touch_en     = 1'b0;
        touch_set    = req_idx;
        touch_way    = hit_way;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                end else if (mem_read) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        touch_en = 1'b1;
                    end else begin
                        state_d  = FETCH;
                        victim_d = inv_found ? inv_way : plru_way;
                        line_d   = mem_address[31:OFF_W];
                    end
                end
            end
            FETCH: begin
                pmem_read = 1'b1;
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (pmem_resp) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                mem_resp  = 1'b1;
                touch_en  = 1'b1;
                touch_set = fill_idx;
                touch_way = victim_q;
                state_d   = flush_pend_q ? FLUSH : IDLE;
            end
            FLUSH: begin
                flush_ack    = 1'b1;
                flush_pend_d = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fill_we = (state_q == FETCH) && pmem_resp;

    always_comb begin
        valid_d = valid_q;
        if (state_q == FLUSH) begin
            valid_d = '{default: '0};
        end else if (fill_we) begin
            valid_d[fill_idx][victim_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
            victim_q     <= '0;
            line_q       <= '0;
            valid_q      <= '{default: '0};
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            victim_q     <= victim_d;
            line_q       <= line_d;
            valid_q      <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_idx][victim_q]  <= fill_tag;
            data_q[fill_idx][victim_q] <= pmem_rdata;
        end
    end

    assign rd_set       = (state_q == RESP) ? fill_idx : req_idx;
    assign rd_way       = (state_q == RESP) ? victim_q : hit_way;
    assign mem_rdata    = data_q[rd_set][rd_way];
    assign pmem_address = {line_q, {OFF_W{1'b0}}};

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic        idle_req;

    assign idle_req = (state_q == IDLE) && !flush && mem_read;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (idle_req && hit) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (idle_req && !hit) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_nway.sv
`default_nettype none
// ============================================================================
// Module  : tb_icache_nway
// Purpose : Directed scoreboard bench for icache_nway (WAYS=4, SETS=8, 256-bit lines).
// Revision: 1.0
// ============================================================================
module tb_icache_nway;
    import icache_pkg::*;

    logic         clk;
    logic         rst;
    logic         mem_read;
    logic [31:0]  mem_address;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic         flush;
    logic         flush_ack;
    logic         pmem_read;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int checks = 0;
    int errors = 0;
    int flush_exp = 0;
    logic [255:0] exp_q [$];

    icache_nway #(
        .WAYS      (4),
        .SETS      (8),
        .LINE_BITS (256)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .flush        (flush),
        .flush_ack    (flush_ack),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory: every line carries a pattern unique to its address.
    function automatic logic [255:0] model(input logic [31:0] a);
        return {4{a ^ 32'hC0DE_0000, ~a}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mem_resp) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected got=%h want=none", mem_rdata);
            end else begin
                logic [255:0] e;
                e = exp_q.pop_front();
                if (mem_rdata !== e) begin
                    errors++;
                    $display("FAIL resp_data got=%h want=%h", mem_rdata, e);
                end
            end
        end
        if (flush_ack) begin
            checks++;
            if (flush_exp == 0) begin
                errors++;
                $display("FAIL flush_ack_unexpected got=1 want=0");
            end else begin
                flush_exp--;
            end
        end
    end

    task automatic wait_pmem(output bit got);
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (pmem_read) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL pmem_read_timeout got=0 want=1");
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input bit exp_hit, input bit with_flush);
        logic [255:0] d;
        bit got;
        d = model(addr);
        exp_q.push_back(d);
        if (with_flush) flush_exp++;
        @(posedge clk); #1;
        mem_read    = 1'b1;
        mem_address = addr;
        @(negedge clk);
        check($sformatf("hit_%0h", addr), 64'(mem_resp), 64'(exp_hit));
        if (exp_hit) check($sformatf("hit_nopmem_%0h", addr), 64'(pmem_read), 64'd0);
        if (!mem_resp) begin
            wait_pmem(got);
            if (got) begin
                check($sformatf("pmem_addr_%0h", addr), 64'(pmem_address),
                      64'({addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}}));
                if (with_flush) begin
                    @(posedge clk); #1 flush = 1'b1;
                end
                @(posedge clk); #1;
                flush      = 1'b0;
                pmem_rdata = d;
                pmem_resp  = 1'b1;
                @(posedge clk); #1 pmem_resp = 1'b0;
                @(negedge clk);
                check($sformatf("miss_lat_%0h", addr), 64'(mem_resp), 64'd1);
                if (with_flush) begin
                    @(negedge clk);
                    check("flush_ack_after_resp", 64'(flush_ack), 64'd1);
                end
            end
        end
        @(posedge clk); #1 mem_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit got;
        rst         = 1'b0;
        mem_read    = 1'b0;
        mem_address = '0;
        flush       = 1'b0;
        pmem_rdata  = '0;
        pmem_resp   = 1'b0;
        #12;
        check("rst_mem_resp",  64'(mem_resp),  64'd0);
        check("rst_pmem_read", 64'(pmem_read), 64'd0);
        check("rst_flush_ack", 64'(flush_ack), 64'd0);
        @(negedge clk); rst = 1'b1;

        // Cold miss then same-cycle hit.
        do_read(32'h040, 1'b0, 1'b0);
        do_read(32'h040, 1'b1, 1'b0);

        // Set 0 fills ways 0..3; 0x400 must evict way0 (0x000).
        do_read(32'h000, 1'b0, 1'b0);
        do_read(32'h100, 1'b0, 1'b0);
        do_read(32'h200, 1'b0, 1'b0);
        do_read(32'h300, 1'b0, 1'b0);
        do_read(32'h400, 1'b0, 1'b0);
        do_read(32'h000, 1'b0, 1'b0);

        // Set 1: touching way0 steers the next victim to way2 (0x220).
        do_read(32'h020, 1'b0, 1'b0);
        do_read(32'h120, 1'b0, 1'b0);
        do_read(32'h220, 1'b0, 1'b0);
        do_read(32'h320, 1'b0, 1'b0);
        do_read(32'h020, 1'b1, 1'b0);
        do_read(32'h420, 1'b0, 1'b0);
        do_read(32'h220, 1'b0, 1'b0);
        do_read(32'h020, 1'b1, 1'b0);
        do_read(32'h320, 1'b1, 1'b0);

        // Flush raised during a fill: response first, then flush_ack, then all lines gone.
        do_read(32'h060, 1'b0, 1'b1);
        do_read(32'h040, 1'b0, 1'b0);
        do_read(32'h020, 1'b0, 1'b0);
        do_read(32'h060, 1'b0, 1'b0);

        // Reset mid-fill aborts the request without a response.
        @(posedge clk); #1;
        mem_read    = 1'b1;
        mem_address = 32'h080;
        wait_pmem(got);
        #2 rst = 1'b0;
        #1;
        check("rst_abort_pmem_read", 64'(pmem_read), 64'd0);
        check("rst_abort_mem_resp",  64'(mem_resp),  64'd0);
        mem_read = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 3 misses and 5 hits after reset.
        do_read(32'h040, 1'b0, 1'b0);
        do_read(32'h000, 1'b0, 1'b0);
        do_read(32'h100, 1'b0, 1'b0);
        do_read(32'h040, 1'b1, 1'b0);
        do_read(32'h000, 1'b1, 1'b0);
        do_read(32'h100, 1'b1, 1'b0);
        do_read(32'h040, 1'b1, 1'b0);
        do_read(32'h000, 1'b1, 1'b0);
`ifdef ICACHE_PERF_CNT_EN
        @(negedge clk);
        check("miss_count", 64'(miss_count), 64'd3);
        check("hit_count",  64'(hit_count),  64'd5);
`endif

        repeat (3) @(negedge clk);
        check("resp_outstanding",  64'(exp_q.size()), 64'd0);
        check("flush_outstanding", 64'(flush_exp),     64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
